camera_sccb_cfg: RTL

//  Power-up configuration sequencer for the image sensor feeding the capture path.

---
 rtl/camera_pkg.sv | 30 +++
 rtl/sccb_tick_gen.sv | 31 +++
 rtl/camera_sccb_cfg.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// camera_pkg: shared types and constants for the sensor configuration sequencer.
//   cfg_state_t : sequencer states
//   CFG_END     : table end marker
//   CFG_DELAY   : table delay marker
//   Q_* / BIT_* : quarter-phase and bit positions within an SCCB write
package camera_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_DELAY,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } cfg_state_t;

  localparam logic [15:0] CFG_END      = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY    = 16'hFFF0;

  localparam logic [1:0]  Q_START_LAST = 2'd1;   // START is two quarters
  localparam logic [1:0]  Q_BIT_LAST   = 2'd3;   // each bit is four quarters
  localparam logic [1:0]  Q_STOP_LAST  = 2'd2;   // STOP is three quarters
  localparam logic [3:0]  BIT_ACK      = 4'd8;   // ninth (don't-care) bit
  localparam logic [1:0]  BYTE_LAST    = 2'd2;   // ID, sub-addr, data
  localparam logic [3:0]  GAP_LAST     = 4'd15;  // 16 idle quarters

endpackage

// File: rtl/sccb_tick_gen.sv
// sccb_tick_gen: quarter-bit timing base for the SCCB master.
//   clk     in  system clock
//   rst_n   in  async active-low reset
//   restart in  synchronous restart; next tick arrives QDIV clk later
//   tick    out 1-clk pulse every QDIV clk
module sccb_tick_gen #(
  parameter int unsigned QDIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == CW'(QDIV - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(QDIV - 1));

endmodule

// File: rtl/camera_sccb_cfg.sv
// camera_sccb_cfg: power-up configuration sequencer for the image sensor.
// Walks an external register table and issues one 3-phase SCCB write
// (DEV_ID, reg_addr, reg_data) per entry; 16'hFFFF ends the table,
// 16'hFFF0 inserts a DELAY_CYC pause.
//   clk, rst_n        clock, async active-low reset
//   start             1-clk pulse, rerun table (ignored unless idle)
//   tbl_idx/tbl_data  table index out, {reg_addr, reg_data} in one clk later
//   busy, cfg_done    sequence running / sequence complete (held until start)
//   sio_c             SCCB clock, push-pull
//   sio_d_o/sio_d_oe  SCCB data and its drive enable (0 = released)
module camera_sccb_cfg
  import camera_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 24_000_000,
  parameter int unsigned SCCB_FREQ  = 100_000,
  parameter logic [7:0]  DEV_ID     = 8'h42,
  parameter int unsigned NUM_REGS   = 256,
  parameter int unsigned PWRUP_CYC  = 24_000,
  parameter int unsigned DELAY_CYC  = 240_000,
  parameter logic        AUTO_START = 1'b1,
  localparam int unsigned IW        = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [IW-1:0] tbl_idx,
  input  logic [15:0]   tbl_data,
  output logic          busy,
  output logic          cfg_done,
  output logic          sio_c,
  output logic          sio_d_o,
  output logic          sio_d_oe
);

  localparam int unsigned QDIV = CLK_FREQ / (4 * SCCB_FREQ);

  cfg_state_t  state, state_nxt;
  logic [31:0] wait_cnt;
  logic        fetch_ph;
  logic [15:0] entry;
  logic [1:0]  qph;
  logic [3:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [3:0]  gap_cnt;
  logic [7:0]  shreg;
  logic        auto_pend;
  logic        tick;
  logic        restart;
  logic        go;
  logic        last_idx;
  logic        pwrup_end;
  logic        delay_end;
  logic        c_nxt, d_nxt, oe_nxt, busy_nxt;

  assign go        = (state == ST_IDLE) && (start || auto_pend);
  assign last_idx  = (tbl_idx == IW'(NUM_REGS - 1));
  assign pwrup_end = (wait_cnt == 32'(PWRUP_CYC - 1));
  assign delay_end = (wait_cnt == 32'(DELAY_CYC - 1));
  assign restart   = (state == ST_FETCH) && (state_nxt == ST_START);

  sccb_tick_gen #(
    .QDIV (QDIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The entry is decoded straight from tbl_data on the second FETCH clk; it
  // only steers state, so no path from tbl_data reaches the bus pins.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (go) state_nxt = ST_PWRUP;
      ST_PWRUP: if (pwrup_end) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (fetch_ph) begin
          if (tbl_data == CFG_END)        state_nxt = ST_DONE;
          else if (tbl_data == CFG_DELAY) state_nxt = ST_DELAY;
          else                            state_nxt = ST_START;
        end
      end
      ST_DELAY: if (delay_end) state_nxt = last_idx ? ST_DONE : ST_FETCH;
      ST_START: if (tick && (qph == Q_START_LAST)) state_nxt = ST_BYTE;
      ST_BYTE: begin
        if (tick && (qph == Q_BIT_LAST) && (bit_cnt == BIT_ACK) && (byte_cnt == BYTE_LAST))
          state_nxt = ST_STOP;
      end
      ST_STOP:  if (tick && (qph == Q_STOP_LAST)) state_nxt = ST_GAP;
      ST_GAP:   if (tick && (gap_cnt == GAP_LAST)) state_nxt = last_idx ? ST_DONE : ST_FETCH;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Counters and shift register. Phase counters restart on every state
  // change; within BYTE the 2-bit qph wraps naturally from bit to bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      fetch_ph  <= 1'b0;
      entry     <= '0;
      qph       <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
      tbl_idx   <= '0;
      auto_pend <= AUTO_START;
    end else begin
      if (state != state_nxt) begin
        wait_cnt <= '0;
        fetch_ph <= 1'b0;
        qph      <= '0;
        gap_cnt  <= '0;
      end else begin
        if ((state == ST_PWRUP) || (state == ST_DELAY)) wait_cnt <= wait_cnt + 32'd1;
        if (state == ST_FETCH) fetch_ph <= ~fetch_ph;
        if (tick) begin
          qph <= qph + 2'd1;
          if (state == ST_GAP) gap_cnt <= gap_cnt + 4'd1;
        end
      end

      if (go) begin
        auto_pend <= 1'b0;
        tbl_idx   <= '0;
      end

      if ((state == ST_FETCH) && fetch_ph) entry <= tbl_data;

      if (restart) begin
        shreg    <= DEV_ID;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end

      if ((state == ST_BYTE) && tick && (qph == Q_BIT_LAST)) begin
        if (bit_cnt == BIT_ACK) begin
          bit_cnt  <= '0;
          byte_cnt <= byte_cnt + 2'd1;
          shreg    <= (byte_cnt == 2'd0) ? entry[15:8] : entry[7:0];
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {shreg[6:0], 1'b0};
        end
      end

      if (((state == ST_GAP) || (state == ST_DELAY)) && (state_nxt == ST_FETCH))
        tbl_idx <= tbl_idx + IW'(1);
    end
  end

  // Pin values for the current quarter; the register below delays every pin
  // by the same single clk, so C/D relationships are preserved.
  always_comb begin
    c_nxt    = 1'b1;
    d_nxt    = 1'b1;
    oe_nxt   = 1'b0;
    busy_nxt = !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE));
    unique case (state)
      ST_START: begin
        oe_nxt = 1'b1;
        d_nxt  = (qph == 2'd0);
      end
      ST_BYTE: begin
        c_nxt = qph[1];
        if (bit_cnt == BIT_ACK) begin
          oe_nxt = 1'b0;
          d_nxt  = 1'b1;
        end else begin
          oe_nxt = 1'b1;
          d_nxt  = shreg[7];
        end
      end
      ST_STOP: begin
        oe_nxt = 1'b1;
        c_nxt  = (qph != 2'd0);
        d_nxt  = (qph == Q_STOP_LAST);
      end
      default: begin
        c_nxt  = 1'b1;
        d_nxt  = 1'b1;
        oe_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sio_c    <= 1'b1;
      sio_d_o  <= 1'b1;
      sio_d_oe <= 1'b0;
      busy     <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      sio_c    <= c_nxt;
      sio_d_o  <= d_nxt;
      sio_d_oe <= oe_nxt;
      busy     <= busy_nxt;
      if (go)                          cfg_done <= 1'b0;
      else if (state_nxt == ST_DONE)   cfg_done <= 1'b1;
    end
  end

endmodule
